// File: rtl/res0_event_capture.sv
// -----------------------------------------------------------------------------
// res0_event_capture
//
// Purpose:
//   Watches the four RES0 pins coming from the upstream pass-through stage.
//   It brings them into the UserCLK domain with a two-flop synchroniser and
//   detects edges on the bits that are enabled. Each detected edge is queued
//   in a small FIFO as a {pin snapshot, timestamp} pair. The timestamp comes
//   from a free-running counter. A consumer drains the FIFO with a
//   valid/ready handshake.
//
// Parameters:
//   DEPTH  FIFO entries. Must be a power of two in the range 2..16, so that
//          the pointers wrap naturally at their bit width.
//   TS_W   Timestamp width in bits.
//
// Ports:
//   UserCLK    single clock; all state changes on its rising edge
//   RESETn     asynchronous, active-low reset
//   res_in     raw RES0 pins; asynchronous to UserCLK
//   en         capture enable
//   mask       per-bit event enable
//   clr_ovf    clears the sticky overflow flag
//   evt_ready  consumer accepts the head entry
//   evt_valid  FIFO non-empty
//   evt_data   head entry pin snapshot
//   evt_ts     head entry timestamp
//   evt_count  current occupancy (0..DEPTH)
//   overflow   sticky: an event was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module res0_event_capture #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 12
) (
    input  logic                     UserCLK,
    input  logic                     RESETn,
    input  logic [3:0]               res_in,
    input  logic                     en,
    input  logic [3:0]               mask,
    input  logic                     clr_ovf,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [3:0]               evt_data,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]      data;
        logic [TS_W-1:0] ts;
    } entry_t;

    // Synchroniser chain and edge-detect history
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       prev;

    // Free-running timestamp
    logic [TS_W-1:0]  ts;

    // FIFO storage and bookkeeping
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Per-cycle control
    logic             detect;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // -------------------------------------------------------------------------
    // Synchroniser and timestamp counter.
    // The chain runs whether or not capture is enabled. A pin change that
    // happens while en=0 has therefore left the s2/prev window by the time
    // en rises, so it cannot produce an event later.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge. With blocking assignments,
    // s2 would see the new s1 and the synchroniser would collapse to one stage.
    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
            ts   <= '0;
        end else begin
            s1   <= res_in;
            s2   <= s1;
            prev <= s2;
            ts   <= ts + TS_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Event detection and FIFO control.
    // When the FIFO is full, a push in the same cycle as a pop is accepted:
    // the pop frees the slot at the same edge. A push with no pop is dropped.
    // -------------------------------------------------------------------------
    // NOTE: each signal gets a default at the top of the block. This means no
    // path through the block can leave a signal unassigned, so no latch can
    // be inferred.
    always_comb begin
        detect  = 1'b0;
        full    = 1'b0;
        pop     = 1'b0;
        push_ok = 1'b0;
        drop    = 1'b0;

        detect  = en && (((s2 ^ prev) & mask) != 4'b0000);
        full    = (count == CNT_W'(DEPTH));
        pop     = (count != '0) && evt_ready;
        push_ok = detect && (!full || pop);
        drop    = detect && full && !pop;
    end

    // -------------------------------------------------------------------------
    // FIFO state: pointers, occupancy, storage, sticky overflow.
    // -------------------------------------------------------------------------
    // NOTE: the storage array is reset along with the pointers. This keeps
    // evt_data/evt_ts at 0 during reset and X-free when the FIFO is empty.
    // That behaviour is needed here; at this depth it is cheap.
    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{data: s2, ts: ts};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A drop in the same cycle as a clear wins, so no dropped event
            // goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Head-of-queue outputs. There is no bypass path: a newly pushed entry
    // appears only after it has been written into the array.
    // -------------------------------------------------------------------------
    assign evt_valid = (count != '0);
    assign evt_count = count;
    assign evt_data  = mem[rd_ptr].data;
    assign evt_ts    = mem[rd_ptr].ts;

endmodule

// File: tb/tb_res0_event_capture.sv
// -----------------------------------------------------------------------------
// tb_res0_event_capture
//
// Self-checking bench for res0_event_capture. The DUT uses DEPTH=4 and TS_W=4,
// so the timestamp wraps frequently. The reference model is an event queue.
// It is driven from a short history of res_in samples taken at each clock
// edge, and from a count of edges since reset.
// -----------------------------------------------------------------------------
module tb_res0_event_capture;

    localparam int DEPTH = 4;
    localparam int TS_W  = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             UserCLK = 1'b0;
    logic             RESETn  = 1'b1;
    logic [3:0]       res_in  = 4'h0;
    logic             en      = 1'b0;
    logic [3:0]       mask    = 4'h0;
    logic             clr_ovf = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [3:0]       evt_data;
    logic [TS_W-1:0]  evt_ts;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    res0_event_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .UserCLK   (UserCLK),
        .RESETn    (RESETn),
        .res_in    (res_in),
        .en        (en),
        .mask      (mask),
        .clr_ovf   (clr_ovf),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ts    (evt_ts),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    always #5 UserCLK = ~UserCLK;

    // ------------------------------------------------------------------
    // Reference model.
    // samp_hist[0] holds the res_in value sampled at the latest edge,
    // samp_hist[1] the value at the edge before, and so on. An event fires
    // when the two older samples differ on an enabled bit. The event records
    // the newer of those two samples and the number of edges since reset.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]      d;
        logic [TS_W-1:0] t;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  samp_hist[$];
    int unsigned edges;
    bit          movf;

    task automatic model_reset();
        mq.delete();
        samp_hist = '{4'h0, 4'h0, 4'h0};
        edges = 0;
        movf  = 1'b0;
    endtask

    // Called with the inputs that the DUT will sample at the coming edge.
    task automatic model_step();
        bit   ev;
        bit   drop;
        ent_t e;
        ev   = en && (((samp_hist[1] ^ samp_hist[2]) & mask) != 4'h0);
        drop = 1'b0;
        if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
        if (ev) begin
            e.d = samp_hist[1];
            e.t = TS_W'(edges % (1 << TS_W));
            if (mq.size() < DEPTH) mq.push_back(e);
            else drop = 1'b1;
        end
        if (drop) movf = 1'b1;
        else if (clr_ovf) movf = 1'b0;
        samp_hist.push_front(res_in);
        void'(samp_hist.pop_back());
        edges++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            model_step();
            @(posedge UserCLK);
            #1;
        end
    endtask

    task automatic reset_on();
        RESETn = 1'b0;
        model_reset();
        #1;
    endtask

    // Holds reset across one edge, then releases it just after an edge.
    task automatic reset_off();
        @(posedge UserCLK);
        #1;
        RESETn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        RESETn = 1'b1;
        #2;
        reset_on();
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
        checks++; if (evt_count !== '0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        checks++; if (evt_data !== 4'h0)  begin failures++; $display("FAIL reset_data got=%0h exp=0", evt_data); end
        checks++; if (evt_ts !== '0)      begin failures++; $display("FAIL reset_ts got=%0d exp=0", evt_ts); end
        reset_off();
    endtask

    task automatic test_single_event();
        reset_on();
        en = 1'b1; mask = 4'hF; evt_ready = 1'b0; res_in = 4'h0; clr_ovf = 1'b0;
        reset_off();
        tick(9);
        res_in = 4'h1;
        tick(2);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%0b exp=0", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", evt_valid); end
        checks++; if (evt_data !== 4'h1)  begin failures++; $display("FAIL single_data got=%0h exp=1", evt_data); end
        checks++; if (evt_ts !== 4'd11)   begin failures++; $display("FAIL single_ts got=%0d exp=11", evt_ts); end
        checks++; if (evt_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", evt_count); end
        tick(3);
        checks++; if (evt_data !== 4'h1 || evt_ts !== 4'd11) begin failures++; $display("FAIL single_hold got=%0h/%0d exp=1/11", evt_data, evt_ts); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin failures++; $display("FAIL single_pop got=%0b/%0d exp=0/0", evt_valid, evt_count); end
    endtask

    task automatic test_mask();
        reset_on();
        en = 1'b1; mask = 4'h2; evt_ready = 1'b0; res_in = 4'h0;
        reset_off();
        tick(3);
        res_in = 4'h1;
        tick(3);
        res_in = 4'h3;
        tick(6);
        checks++; if (evt_count !== 3'd1) begin failures++; $display("FAIL mask_count got=%0d exp=1", evt_count); end
        checks++; if (evt_data !== 4'h3)  begin failures++; $display("FAIL mask_data got=%0h exp=3", evt_data); end
        checks++; if (evt_ts !== 4'd8)    begin failures++; $display("FAIL mask_ts got=%0d exp=8", evt_ts); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_d [4] = '{4'h1, 4'h0, 4'h1, 4'h0};
        logic [3:0] exp_t [4] = '{4'd2, 4'd5, 4'd8, 4'd11};
        reset_on();
        en = 1'b1; mask = 4'hF; evt_ready = 1'b0; res_in = 4'h0;
        reset_off();
        for (int i = 0; i < 5; i++) begin
            res_in = res_in ^ 4'h1;
            tick(3);
        end
        tick(2);
        checks++; if (evt_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", evt_count); end
        checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        tick(2);
        checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
        evt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== exp_d[j] || evt_ts !== exp_t[j]) begin
                failures++;
                $display("FAIL ovf_order[%0d] got=%0b/%0h/%0d exp=1/%0h/%0d", j, evt_valid, evt_data, evt_ts, exp_d[j], exp_t[j]);
            end
            tick(1);
        end
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", evt_valid); end
    endtask

    // Runs straight after test_overflow: FIFO empty, res_in=1, overflow clear.
    task automatic test_full_pop();
        logic [3:0] exp_d [4] = '{4'h1, 4'h0, 4'h1, 4'h0};
        for (int i = 0; i < 4; i++) begin
            res_in = res_in ^ 4'h1;
            tick(3);
        end
        checks++; if (evt_count !== 3'd4) begin failures++; $display("FAIL fullpop_fill got=%0d exp=4", evt_count); end
        res_in = res_in ^ 4'h1;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL fullpop_ovf got=%0b exp=0", overflow); end
        checks++; if (evt_count !== 3'd4) begin failures++; $display("FAIL fullpop_count got=%0d exp=4", evt_count); end
        evt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (evt_data !== exp_d[j]) begin failures++; $display("FAIL fullpop_order[%0d] got=%0h exp=%0h", j, evt_data, exp_d[j]); end
            tick(1);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_gating();
        en = 1'b0; mask = 4'hF;
        res_in = res_in ^ 4'h4;
        tick(4);
        en = 1'b1;
        tick(4);
        checks++; if (evt_count !== 3'd0) begin failures++; $display("FAIL gate_en got=%0d exp=0", evt_count); end
        mask = 4'h0;
        res_in = res_in ^ 4'h8;
        tick(4);
        mask = 4'hF;
        tick(4);
        checks++; if (evt_count !== 3'd0) begin failures++; $display("FAIL gate_mask got=%0d exp=0", evt_count); end
    endtask

    task automatic test_ts_wrap();
        reset_on();
        en = 1'b1; mask = 4'hF; evt_ready = 1'b0; res_in = 4'h0;
        reset_off();
        tick(13);
        res_in = 4'h1;
        tick(16);
        res_in = 4'h0;
        tick(4);
        checks++; if (evt_count !== 3'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", evt_count); end
        checks++; if (evt_data !== 4'h1 || evt_ts !== 4'd15) begin failures++; $display("FAIL wrap_first got=%0h/%0d exp=1/15", evt_data, evt_ts); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_data !== 4'h0 || evt_ts !== 4'd15) begin failures++; $display("FAIL wrap_second got=%0h/%0d exp=0/15", evt_data, evt_ts); end
    endtask

    // Runs straight after test_ts_wrap: one entry queued, res_in=0.
    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            res_in = res_in ^ 4'h1;
            tick(3);
        end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_count !== 3'd3 || overflow !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0d/%0b exp=3/1", evt_count, overflow); end
        res_in = 4'h1;
        reset_on();
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", evt_valid); end
        checks++; if (evt_count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", evt_count); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL midrst_ovf got=%0b exp=0", overflow); end
        reset_off();
        tick(2);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL midrst_early got=%0b exp=0", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1 || evt_data !== 4'h1 || evt_ts !== 4'd2) begin
            failures++;
            $display("FAIL midrst_restart got=%0b/%0h/%0d exp=1/1/2", evt_valid, evt_data, evt_ts);
        end
    endtask

    task automatic test_random();
        ent_t h;
        reset_on();
        res_in = 4'($urandom); en = 1'b1; mask = 4'hF; evt_ready = 1'b0; clr_ovf = 1'b0;
        reset_off();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) res_in = 4'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            mask      = 4'($urandom_range(0, 15));
            evt_ready = ($urandom_range(0, 2) == 0);
            clr_ovf   = ($urandom_range(0, 9) == 0);
            tick(1);
            checks++;
            if (evt_count !== CNT_W'(mq.size()) || evt_valid !== (mq.size() > 0) || overflow !== movf) begin
                failures++;
                $display("FAIL rand_state cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", c, evt_count, evt_valid, overflow, mq.size(), mq.size() > 0, movf);
            end
            if (mq.size() > 0) begin
                h = mq[0];
                checks++;
                if (evt_data !== h.d || evt_ts !== h.t) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d got=%0h/%0d exp=%0h/%0d", c, evt_data, evt_ts, h.d, h.t);
                end
            end
        end
        evt_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_event();
        test_mask();
        test_overflow();
        test_full_pop();
        test_gating();
        test_ts_wrap();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
